// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, types and helpers for the row-DCT butterfly stage.
//   DCT_N / DCT_DW   : default row length and sample width
//   dct_level_shift  : JPEG level-shift constant 2^(dw-1)
//   dct_term_t       : signed (DCT_DW+1) butterfly term
//   dct_term_lsb     : LSB position of term idx in a packed output vector
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int DCT_DW = 8;

  typedef logic signed [DCT_DW:0] dct_term_t;

  function automatic int dct_level_shift(input int dw);
    return 1 << (dw - 1);
  endfunction

  function automatic int dct_term_lsb(input int idx, input int dw);
    return idx * (dw + 1);
  endfunction

endpackage

// File: rtl/dct_butterfly_pair.sv
// dct_butterfly_pair: combinational sum and difference of one sample pair.
//   a_i, b_i : signed DW-bit operands
//   sum_o    : a + b, exact, signed DW+1 bits
//   diff_o   : a - b, exact, signed DW+1 bits
module dct_butterfly_pair #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW:0]   sum_o,
  output logic [DW:0]   diff_o
);

  logic signed [DW:0] a_s;
  logic signed [DW:0] b_s;

  // Sign-extend by one bit so the sum/difference can never overflow.
  assign a_s    = {a_i[DW-1], a_i};
  assign b_s    = {b_i[DW-1], b_i};
  assign sum_o  = a_s + b_s;
  assign diff_o = a_s - b_s;

endmodule

// File: rtl/dct_row_butterfly.sv
// dct_row_butterfly: collects an N-sample row over a valid/ready stream and
// emits the N/2 even (sum) and N/2 odd (difference) first-stage DCT terms.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : sample handshake, in_data DW bits
//   out_valid/out_ready  : result handshake
//   out_even, out_odd    : packed signed (DW+1) terms, term i at [i*(DW+1) +: DW+1]
//   out_row              : row index of the result within the N-row block
// Build option: DCT_LEVEL_SHIFT_EN treats in_data as unsigned and subtracts
// 2^(DW-1) before use; otherwise in_data is taken as signed two's complement.
module dct_row_butterfly
  import dct_pkg::*;
#(
  parameter int DW = DCT_DW,
  parameter int N  = DCT_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(N/2)*(DW+1)-1:0]   out_even,
  output logic [(N/2)*(DW+1)-1:0]   out_odd,
  output logic [$clog2(N)-1:0]      out_row
);

  localparam int HALF = N / 2;
  localparam int TW   = DW + 1;
  localparam int CW   = $clog2(N);
  localparam int HW   = HALF * TW;
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          out_valid_q, out_valid_d;
  logic [HW-1:0] out_even_q, out_even_d;
  logic [HW-1:0] out_odd_q, out_odd_d;
  logic [CW-1:0] out_row_q, out_row_d;
  logic [DW-1:0] x_q [0:N-2];

  logic [DW-1:0] sample_s;
  logic          last_s;
  logic          accept_s;
  logic          load_s;
  logic [HW-1:0] sum_s;
  logic [HW-1:0] diff_s;

`ifdef DCT_LEVEL_SHIFT_EN
  localparam logic [DW-1:0] SHIFT_C = DW'(dct_level_shift(DW));
  // Modulo-2^DW subtraction maps unsigned 0..2^DW-1 onto signed -2^(DW-1)..2^(DW-1)-1.
  assign sample_s = in_data - SHIFT_C;
`else
  assign sample_s = in_data;
`endif

  assign last_s   = (col_q == LAST_C);
  // Only the row-completing sample can be blocked by an undrained result.
  assign in_ready = !last_s || !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign load_s   = accept_s && last_s;

  // One butterfly per (x[i], x[N-1-i]) pair; x[N-1] is the live sample.
  for (genvar gi = 0; gi < HALF; gi++) begin : g_pair
    localparam int LSB = dct_term_lsb(gi, DW);
    logic [DW-1:0] hi_s;
    if (gi == 0) begin : g_live
      assign hi_s = sample_s;
    end else begin : g_buf
      assign hi_s = x_q[N-1-gi];
    end
    dct_butterfly_pair #(.DW(DW)) u_pair (
      .a_i   (x_q[gi]),
      .b_i   (hi_s),
      .sum_o (sum_s[LSB +: TW]),
      .diff_o(diff_s[LSB +: TW])
    );
  end

  // Next-state for column/row counters and the output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_even_d  = out_even_q;
    out_odd_d   = out_odd_q;
    out_row_d   = out_row_q;

    if (accept_s) begin
      if (last_s) begin
        col_d = {CW{1'b0}};
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end

    // A loading row takes priority over draining, so out_valid stays high.
    if (load_s) begin
      out_valid_d = 1'b1;
      out_even_d  = sum_s;
      out_odd_d   = diff_s;
      out_row_d   = row_q;
      if (row_q == LAST_C) begin
        row_d = {CW{1'b0}};
      end else begin
        row_d = row_q + CW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_even_q  <= {HW{1'b0}};
      out_odd_q   <= {HW{1'b0}};
      out_row_q   <= {CW{1'b0}};
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
      out_row_q   <= out_row_d;
    end
  end

  // Row buffer: holds samples for columns 0..N-2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N - 1; i++) begin
        x_q[i] <= {DW{1'b0}};
      end
    end else if (accept_s && !last_s) begin
      x_q[col_q] <= sample_s;
    end
  end

  assign out_valid = out_valid_q;
  assign out_even  = out_even_q;
  assign out_odd   = out_odd_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_dct_row_butterfly.sv
// tb_dct_row_butterfly: self-checking bench for dct_row_butterfly (DW=8, N=8).
// Results are captured per output handshake and compared with a reference
// model computing the butterfly terms directly from the row of samples.
module tb_dct_row_butterfly;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int CW = $clog2(N);
  localparam int HW = (N / 2) * (DW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] out_even;
  logic [HW-1:0] out_odd;
  logic [CW-1:0] out_row;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_row = 0;

  typedef struct {
    logic [HW-1:0] ev;
    logic [HW-1:0] od;
    logic [CW-1:0] row;
    int            cyc;
  } res_t;
  res_t q[$];

  dct_row_butterfly #(.DW(DW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_even (out_even),
    .out_odd  (out_odd),
    .out_row  (out_row)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every consumed result (inputs change on negedge; sample 2 later).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready)
        q.push_back('{out_even, out_odd, out_row, cyc});
    end
  end

  // Signed value of a sample as the butterfly should see it.
  function automatic int sx(input int d);
`ifdef DCT_LEVEL_SHIFT_EN
    return d - (1 << (DW - 1));
`else
    return (d >= (1 << (DW - 1))) ? d - (1 << DW) : d;
`endif
  endfunction

  function automatic logic [HW-1:0] exp_even(input int r[N]);
    logic [HW-1:0] v;
    v = '0;
    for (int i = 0; i < N / 2; i++)
      v[i*(DW+1) +: DW+1] = (DW+1)'(sx(r[i]) + sx(r[N-1-i]));
    return v;
  endfunction

  function automatic logic [HW-1:0] exp_odd(input int r[N]);
    logic [HW-1:0] v;
    v = '0;
    for (int i = 0; i < N / 2; i++)
      v[i*(DW+1) +: DW+1] = (DW+1)'(sx(r[i]) - sx(r[N-1-i]));
    return v;
  endfunction

  // Drive one sample starting at a negedge; returns at the negedge after acceptance.
  task automatic send_sample(input int v);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = v[DW-1:0];
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = DW'($urandom);
    repeat (3) @(negedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    tests++; if (out_even !== '0) begin fails++; $display("FAIL reset_even: got %h required 0", out_even); end
    tests++; if (out_odd !== '0) begin fails++; $display("FAIL reset_odd: got %h required 0", out_odd); end
    tests++; if (out_row !== '0) begin fails++; $display("FAIL reset_row: got %0d required 0", out_row); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_row = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed;
    int r[N];
    int nrows;
`ifdef DCT_LEVEL_SHIFT_EN
    nrows = 3;
`else
    nrows = 1;
`endif
    out_ready = 1'b1;
    for (int k = 0; k < nrows; k++) begin
      for (int i = 0; i < N; i++) begin
`ifdef DCT_LEVEL_SHIFT_EN
        r[i] = (k == 0) ? 128 : (k == 1) ? 255 : 0;
`else
        r[i] = 10 * (i + 1);
`endif
      end
      q.delete();
      for (int i = 0; i < N; i++) send_sample(r[i]);
      #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dir_latency: out_valid=%b required 1", out_valid); end
      tests++; if (out_even !== exp_even(r)) begin fails++; $display("FAIL dir_even row%0d: got %h required %h", k, out_even, exp_even(r)); end
      tests++; if (out_odd !== exp_odd(r)) begin fails++; $display("FAIL dir_odd row%0d: got %h required %h", k, out_odd, exp_odd(r)); end
      tests++; if (out_row !== CW'(exp_row)) begin fails++; $display("FAIL dir_row: got %0d required %0d", out_row, exp_row); end
`ifndef DCT_LEVEL_SHIFT_EN
      tests++;
      if (out_even !== {4{9'd90}} || out_odd !== {9'h1F6, 9'h1E2, 9'h1CE, 9'h1BA}) begin
        fails++;
        $display("FAIL dir_const: got even %h odd %h", out_even, out_odd);
      end
`endif
      exp_row = (exp_row + 1) % N;
      repeat (2) @(negedge clk);
      tests++; if (q.size() != 1) begin fails++; $display("FAIL dir_count: got %0d results required 1", q.size()); end
    end
  endtask

  task automatic test_random;
    int rows[4][N];
    q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        rows[k][i] = $urandom_range(0, (1 << DW) - 1);
        send_sample(rows[k][i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    for (int t = 0; t < 20 && q.size() < 4; t++) @(negedge clk);
    tests++;
    if (q.size() != 4) begin
      fails++;
      $display("FAIL rand_count: got %0d results required 4", q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (q[k].ev !== exp_even(rows[k]) || q[k].od !== exp_odd(rows[k]) || q[k].row !== CW'(exp_row)) begin
          fails++;
          $display("FAIL rand_row%0d: got e=%h o=%h r=%0d required e=%h o=%h r=%0d", k,
                   q[k].ev, q[k].od, q[k].row, exp_even(rows[k]), exp_odd(rows[k]), exp_row);
        end
        exp_row = (exp_row + 1) % N;
      end
    end
  endtask

  task automatic test_backpressure;
    int ra[N];
    int rb[N];
    int row_a;
    q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom_range(0, (1 << DW) - 1);
      rb[i] = $urandom_range(0, (1 << DW) - 1);
    end
    for (int i = 0; i < N; i++) send_sample(ra[i]);
    row_a = exp_row;
    for (int i = 0; i < N - 1; i++) send_sample(rb[i]);
    in_valid = 1'b1;
    in_data = rb[N-1][DW-1:0];
    repeat (3) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: in_ready=%b required 0", in_ready); end
      tests++; if (out_valid !== 1'b1 || out_row !== CW'(row_a)) begin
        fails++; $display("FAIL bp_hold: valid=%b row=%0d required 1 row %0d", out_valid, out_row, row_a); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready=%b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && q.size() < 2; t++) @(negedge clk);
    tests++;
    if (q.size() != 2) begin
      fails++;
      $display("FAIL bp_count: got %0d results required 2", q.size());
    end else begin
      tests++;
      if (q[0].ev !== exp_even(ra) || q[0].od !== exp_odd(ra) || q[0].row !== CW'(row_a)) begin
        fails++; $display("FAIL bp_rowA: got e=%h o=%h r=%0d required e=%h o=%h r=%0d",
                          q[0].ev, q[0].od, q[0].row, exp_even(ra), exp_odd(ra), row_a);
      end
      tests++;
      if (q[1].ev !== exp_even(rb) || q[1].od !== exp_odd(rb) || q[1].row !== CW'((row_a + 1) % N)) begin
        fails++; $display("FAIL bp_rowB: got e=%h o=%h r=%0d required e=%h o=%h r=%0d",
                          q[1].ev, q[1].od, q[1].row, exp_even(rb), exp_odd(rb), (row_a + 1) % N);
      end
      tests++;
      if (q[1].cyc - q[0].cyc != 1) begin
        fails++; $display("FAIL bp_latency: gap %0d cycles required 1", q[1].cyc - q[0].cyc);
      end
    end
    exp_row = (row_a + 2) % N;
  endtask

  task automatic test_reset_midrow;
    int r[N];
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_sample($urandom_range(0, (1 << DW) - 1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_row = 0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      r[i] = $urandom_range(0, (1 << DW) - 1);
      send_sample(r[i]);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (q.size() != 1) begin
      fails++;
      $display("FAIL rst_mid_count: got %0d results required 1", q.size());
    end else begin
      tests++;
      if (q[0].ev !== exp_even(r) || q[0].od !== exp_odd(r) || q[0].row !== CW'(0)) begin
        fails++; $display("FAIL rst_mid_row: got e=%h o=%h r=%0d required e=%h o=%h r=0",
                          q[0].ev, q[0].od, q[0].row, exp_even(r), exp_odd(r));
      end
    end
    exp_row = 1;
  endtask

  task automatic test_back_to_back;
    int rows[9][N];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_row = 0;
    q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++)
      for (int i = 0; i < N; i++) begin
        rows[k][i] = $urandom_range(0, (1 << DW) - 1);
        send_sample(rows[k][i]);
      end
    for (int t = 0; t < 20 && q.size() < 9; t++) @(negedge clk);
    tests++;
    if (q.size() != 9) begin
      fails++;
      $display("FAIL b2b_count: got %0d results required 9", q.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        tests++;
        if (q[k].ev !== exp_even(rows[k]) || q[k].od !== exp_odd(rows[k]) || q[k].row !== CW'(k % N)) begin
          fails++; $display("FAIL b2b_row%0d: got e=%h o=%h r=%0d required e=%h o=%h r=%0d", k,
                            q[k].ev, q[k].od, q[k].row, exp_even(rows[k]), exp_odd(rows[k]), k % N);
        end
        if (k > 0) begin
          tests++;
          if (q[k].cyc - q[k-1].cyc != N) begin
            fails++; $display("FAIL b2b_gap%0d: got %0d cycles required %0d", k, q[k].cyc - q[k-1].cyc, N);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
